// File: rtl/alu_issue_stage.sv
// Two-entry issue buffer ahead of the ALU: skid storage, writeback snoop and RAW handling.
// Define ALU_ISSUE_FORWARD_EN for output bypass; otherwise a matching head entry is held.
module alu_issue_stage (
   input  logic        clk,
   input  logic        rst,
   input  logic        flush,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [15:0] in_a,
   input  logic [15:0] in_b,
   input  logic [2:0]  in_rs_a,
   input  logic [2:0]  in_rs_b,
   input  logic        in_use_a,
   input  logic        in_use_b,
   input  logic [2:0]  in_rd,
   input  logic        in_wr,
   input  logic        in_cin,
   input  logic [3:0]  in_op,
   input  logic        in_inva,
   input  logic        in_invb,
   input  logic        in_sign,
   input  logic        exm_wr,
   input  logic [2:0]  exm_rd,
   input  logic [15:0] exm_data,
   input  logic        mwb_wr,
   input  logic [2:0]  mwb_rd,
   input  logic [15:0] mwb_data,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [15:0] A,
   output logic [15:0] B,
   output logic        Cin,
   output logic [3:0]  Op,
   output logic        invA,
   output logic        invB,
   output logic        sign,
   output logic [2:0]  out_rd,
   output logic        out_wr
);

   typedef struct packed {
      logic [15:0] a;
      logic [15:0] b;
      logic [2:0]  rs_a;
      logic [2:0]  rs_b;
      logic        use_a;
      logic        use_b;
      logic [2:0]  rd;
      logic        wr;
      logic        cin;
      logic [3:0]  op;
      logic        inva;
      logic        invb;
      logic        sign;
   } entry_t;

   entry_t      mem [2];
   logic        head;
   logic        tail;
   logic [1:0]  count;
   logic [1:0]  valid;
   entry_t      hd;
   entry_t      in_e;
   logic        push;
   logic        pop;
   logic        hold;
   logic        present;
   logic        a_exm, a_mwb, b_exm, b_mwb;

   // Replace any used source operand that MEM/WB is writing this cycle.
   function automatic entry_t snoop(input entry_t e);
      entry_t r;
      r = e;
      if (mwb_wr && e.use_a && (e.rs_a == mwb_rd)) r.a = mwb_data;
      if (mwb_wr && e.use_b && (e.rs_b == mwb_rd)) r.b = mwb_data;
      return r;
   endfunction

   assign hd    = mem[head];
   assign in_e  = snoop('{a: in_a, b: in_b, rs_a: in_rs_a, rs_b: in_rs_b,
                          use_a: in_use_a, use_b: in_use_b, rd: in_rd, wr: in_wr,
                          cin: in_cin, op: in_op, inva: in_inva, invb: in_invb,
                          sign: in_sign});

   assign valid[0] = (count == 2'd2) || ((count == 2'd1) && (head == 1'b0));
   assign valid[1] = (count == 2'd2) || ((count == 2'd1) && (head == 1'b1));

   assign a_exm = hd.use_a && exm_wr && (exm_rd == hd.rs_a);
   assign a_mwb = hd.use_a && mwb_wr && (mwb_rd == hd.rs_a);
   assign b_exm = hd.use_b && exm_wr && (exm_rd == hd.rs_b);
   assign b_mwb = hd.use_b && mwb_wr && (mwb_rd == hd.rs_b);

`ifdef ALU_ISSUE_FORWARD_EN
   assign hold = 1'b0;
`else
   assign hold = a_exm || a_mwb || b_exm || b_mwb;
`endif

   assign present   = (count != 2'd0) && !hold;
   assign out_valid = present;
   assign in_ready  = rst && (count != 2'd2);
   assign push      = in_valid && in_ready;
   assign pop       = present && out_ready;

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!rst) begin
         count <= 2'd0;
         head  <= 1'b0;
         tail  <= 1'b0;
      end else if (flush) begin
         count <= 2'd0;
         head  <= 1'b0;
         tail  <= 1'b0;
      end else begin
         if (push) tail <= ~tail;
         if (pop)  head <= ~head;
         case ({push, pop})
            2'b10:   count <= count + 2'd1;
            2'b01:   count <= count - 2'd1;
            default: count <= count;
         endcase
      end
   end

   // NOTE: entry storage has no reset; outputs are gated by count, so stale contents never leak.
   always_ff @(posedge clk) begin
      if (valid[0]) mem[0] <= snoop(mem[0]);
      if (valid[1]) mem[1] <= snoop(mem[1]);
      if (push && !flush) mem[tail] <= in_e;
   end

   // NOTE: every output gets a default first so this block can never infer a latch.
   always_comb begin
      A      = 16'h0000;
      B      = 16'h0000;
      Cin    = 1'b0;
      Op     = 4'h0;
      invA   = 1'b0;
      invB   = 1'b0;
      sign   = 1'b0;
      out_rd = 3'd0;
      out_wr = 1'b0;
      if (present) begin
`ifdef ALU_ISSUE_FORWARD_EN
         A = a_exm ? exm_data : (a_mwb ? mwb_data : hd.a);
         B = b_exm ? exm_data : (b_mwb ? mwb_data : hd.b);
`else
         A = hd.a;
         B = hd.b;
`endif
         Cin    = hd.cin;
         Op     = hd.op;
         invA   = hd.inva;
         invB   = hd.invb;
         sign   = hd.sign;
         out_rd = hd.rd;
         out_wr = hd.wr;
      end
   end

endmodule

// File: tb/tb_alu_issue_stage.sv
// Self-checking bench for alu_issue_stage: directed scenarios plus randomized traffic
// compared against a queue-based reference model of the issue buffer.
module tb_alu_issue_stage;

   logic        clk = 1'b0;
   logic        rst, flush, in_valid, in_ready;
   logic [15:0] in_a, in_b;
   logic [2:0]  in_rs_a, in_rs_b, in_rd;
   logic        in_use_a, in_use_b, in_wr, in_cin, in_inva, in_invb, in_sign;
   logic [3:0]  in_op;
   logic        exm_wr, mwb_wr;
   logic [2:0]  exm_rd, mwb_rd;
   logic [15:0] exm_data, mwb_data;
   logic        out_valid, out_ready;
   logic [15:0] A, B;
   logic        Cin, invA, invB, sign, out_wr;
   logic [3:0]  Op;
   logic [2:0]  out_rd;

   int vectors = 0;
   int miscompares = 0;

   alu_issue_stage dut (
      .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
      .in_a(in_a), .in_b(in_b), .in_rs_a(in_rs_a), .in_rs_b(in_rs_b),
      .in_use_a(in_use_a), .in_use_b(in_use_b), .in_rd(in_rd), .in_wr(in_wr),
      .in_cin(in_cin), .in_op(in_op), .in_inva(in_inva), .in_invb(in_invb), .in_sign(in_sign),
      .exm_wr(exm_wr), .exm_rd(exm_rd), .exm_data(exm_data),
      .mwb_wr(mwb_wr), .mwb_rd(mwb_rd), .mwb_data(mwb_data),
      .out_valid(out_valid), .out_ready(out_ready),
      .A(A), .B(B), .Cin(Cin), .Op(Op), .invA(invA), .invB(invB), .sign(sign),
      .out_rd(out_rd), .out_wr(out_wr)
   );

   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   typedef struct packed {
      logic [15:0] a, b;
      logic [2:0]  rs_a, rs_b;
      logic        use_a, use_b;
      logic [2:0]  rd;
      logic        wr, cin;
      logic [3:0]  op;
      logic        inva, invb, sign;
   } op_t;

   op_t q[$];
   logic        exp_valid, exp_in_ready;
   logic [15:0] exp_a, exp_b;
   logic        exp_cin, exp_inva, exp_invb, exp_sign, exp_wr;
   logic [3:0]  exp_op;
   logic [2:0]  exp_rd;

   function automatic logic hit(logic u, logic [2:0] rs, logic w, logic [2:0] rd);
      return u && w && (rs == rd);
   endfunction

   function automatic void model_outputs();
      op_t h;
      logic held;
      exp_in_ready = rst && (q.size() < 2);
      {exp_valid, exp_a, exp_b, exp_cin, exp_op, exp_inva, exp_invb, exp_sign, exp_rd, exp_wr} = '0;
      if (q.size() > 0) begin
         h = q[0];
`ifdef ALU_ISSUE_FORWARD_EN
         held = 1'b0;
`else
         held = hit(h.use_a, h.rs_a, exm_wr, exm_rd) || hit(h.use_a, h.rs_a, mwb_wr, mwb_rd) ||
                hit(h.use_b, h.rs_b, exm_wr, exm_rd) || hit(h.use_b, h.rs_b, mwb_wr, mwb_rd);
`endif
         if (!held) begin
            exp_valid = 1'b1;
            exp_a = h.a;
            exp_b = h.b;
`ifdef ALU_ISSUE_FORWARD_EN
            if (hit(h.use_a, h.rs_a, exm_wr, exm_rd))      exp_a = exm_data;
            else if (hit(h.use_a, h.rs_a, mwb_wr, mwb_rd)) exp_a = mwb_data;
            if (hit(h.use_b, h.rs_b, exm_wr, exm_rd))      exp_b = exm_data;
            else if (hit(h.use_b, h.rs_b, mwb_wr, mwb_rd)) exp_b = mwb_data;
`endif
            exp_cin = h.cin; exp_op = h.op; exp_inva = h.inva; exp_invb = h.invb;
            exp_sign = h.sign; exp_rd = h.rd; exp_wr = h.wr;
         end
      end
   endfunction

   function automatic void model_update();
      op_t e;
      logic do_pop, do_push;
      if (!rst || flush) begin
         q.delete();
         return;
      end
      model_outputs();
      do_pop  = exp_valid && out_ready;
      do_push = in_valid && (q.size() < 2);
      for (int i = 0; i < q.size(); i++) begin
         e = q[i];
         if (hit(e.use_a, e.rs_a, mwb_wr, mwb_rd)) e.a = mwb_data;
         if (hit(e.use_b, e.rs_b, mwb_wr, mwb_rd)) e.b = mwb_data;
         q[i] = e;
      end
      if (do_pop) void'(q.pop_front());
      if (do_push) begin
         e = '{a: in_a, b: in_b, rs_a: in_rs_a, rs_b: in_rs_b, use_a: in_use_a, use_b: in_use_b,
               rd: in_rd, wr: in_wr, cin: in_cin, op: in_op, inva: in_inva, invb: in_invb,
               sign: in_sign};
         if (hit(e.use_a, e.rs_a, mwb_wr, mwb_rd)) e.a = mwb_data;
         if (hit(e.use_b, e.rs_b, mwb_wr, mwb_rd)) e.b = mwb_data;
         q.push_back(e);
      end
   endfunction

   // Advance one clock: the model follows the edge, inputs change only at the falling edge.
   task automatic tick();
      @(posedge clk);
      model_update();
      @(negedge clk);
   endtask

   task automatic idle_inputs();
      flush = 0; in_valid = 0; in_a = 0; in_b = 0; in_rs_a = 0; in_rs_b = 0;
      in_use_a = 0; in_use_b = 0; in_rd = 0; in_wr = 0; in_cin = 0; in_op = 0;
      in_inva = 0; in_invb = 0; in_sign = 0;
      exm_wr = 0; exm_rd = 0; exm_data = 0; mwb_wr = 0; mwb_rd = 0; mwb_data = 0;
   endtask

   task automatic load_op(logic [15:0] a, logic [15:0] b, logic [2:0] rs_a, logic use_a,
                          logic [3:0] op);
      in_valid = 1; in_a = a; in_b = b; in_rs_a = rs_a; in_use_a = use_a; in_rs_b = 0;
      in_use_b = 0; in_op = op; in_rd = 3'd1; in_wr = 1; in_cin = 0; in_inva = 0;
      in_invb = 0; in_sign = 0;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      idle_inputs();
      out_ready = 1; rst = 0;
      load_op(16'h5555, 16'hAAAA, 3'd0, 0, 4'd2);
      #1;
      vectors++;
      if (in_ready !== 1'b0) begin miscompares++; $display("FAIL reset_in_ready0 got=%b want=0", in_ready); end
      tick();
      #1;
      vectors++;
      if ({in_ready, out_valid, A, B} !== 34'd0) begin
         miscompares++;
         $display("FAIL reset_outputs got rdy=%b vld=%b A=%h B=%h want all 0", in_ready, out_valid, A, B);
      end
      tick();
      rst = 1; in_valid = 0;
      #1;
      vectors++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_release got rdy=%b vld=%b want rdy=1 vld=0", in_ready, out_valid);
      end
   endtask

   task automatic test_single();
      out_ready = 1;
      load_op(16'h1234, 16'h0001, 3'd0, 0, 4'd4);
      tick();
      in_valid = 0;
      #1;
      vectors++;
      if ({out_valid, A, B, Op} !== {1'b1, 16'h1234, 16'h0001, 4'd4}) begin
         miscompares++;
         $display("FAIL single_push got vld=%b A=%h B=%h Op=%h want 1 1234 0001 4", out_valid, A, B, Op);
      end
      tick();
      #1;
      vectors++;
      if (out_valid !== 1'b0) begin miscompares++; $display("FAIL single_pop got vld=%b want 0", out_valid); end
   endtask

   task automatic test_back_to_back();
      out_ready = 0;
      for (int i = 0; i < 3; i++) begin
         load_op(16'h0100 + 16'(i), 16'h0200 + 16'(i), 3'd0, 0, 4'(i + 1));
         #1;
         vectors++;
         if (in_ready !== (i < 2)) begin
            miscompares++;
            $display("FAIL skid_in_ready op%0d got=%b want=%b", i, in_ready, (i < 2));
         end
         tick();
      end
      in_valid = 0; out_ready = 1;
      for (int i = 0; i < 3; i++) begin
         #1;
         vectors++;
         if (i < 2 && {out_valid, A, Op} !== {1'b1, 16'h0100 + 16'(i), 4'(i + 1)}) begin
            miscompares++;
            $display("FAIL skid_order op%0d got vld=%b A=%h Op=%h want 1 %h %h", i, out_valid, A, Op,
                     16'h0100 + 16'(i), 4'(i + 1));
         end else if (i == 2 && out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL skid_drained got vld=%b want 0", out_valid);
         end
         tick();
      end
   endtask

   task automatic test_hazard();
      out_ready = 0;
      load_op(16'h0007, 16'h0002, 3'd3, 1, 4'd5);
      tick();
      in_valid = 0;
      exm_wr = 1; exm_rd = 3; exm_data = 16'hBEEF;
      mwb_wr = 1; mwb_rd = 3; mwb_data = 16'h1111;
      #1;
      vectors++;
`ifdef ALU_ISSUE_FORWARD_EN
      if (out_valid !== 1'b1 || A !== 16'hBEEF) begin
         miscompares++; $display("FAIL hazard_forward got vld=%b A=%h want 1 BEEF", out_valid, A);
      end
`else
      if (out_valid !== 1'b0 || A !== 16'h0000) begin
         miscompares++; $display("FAIL hazard_hold got vld=%b A=%h want 0 0000", out_valid, A);
      end
`endif
      tick();
      mwb_wr = 0;
      #1;
      vectors++;
`ifdef ALU_ISSUE_FORWARD_EN
      if (out_valid !== 1'b1 || A !== 16'hBEEF) begin
         miscompares++; $display("FAIL hazard_exm_only got vld=%b A=%h want 1 BEEF", out_valid, A);
      end
`else
      if (out_valid !== 1'b0) begin
         miscompares++; $display("FAIL hazard_exm_hold got vld=%b want 0", out_valid);
      end
`endif
      tick();
      exm_wr = 0;
      #1;
      vectors++;
      if (out_valid !== 1'b1 || A !== 16'h1111 || B !== 16'h0002) begin
         miscompares++;
         $display("FAIL hazard_release got vld=%b A=%h B=%h want 1 1111 0002", out_valid, A, B);
      end
      out_ready = 1;
      tick();
   endtask

   task automatic test_flush();
      out_ready = 0;
      load_op(16'h00F1, 16'h0000, 3'd0, 0, 4'd1);
      tick();
      load_op(16'h00F2, 16'h0000, 3'd0, 0, 4'd2);
      tick();
      #1;
      vectors++;
      if (in_ready !== 1'b0) begin miscompares++; $display("FAIL flush_full got rdy=%b want 0", in_ready); end
      flush = 1;
      load_op(16'h00F3, 16'h0000, 3'd0, 0, 4'd3);
      tick();
      flush = 0; in_valid = 0; out_ready = 1;
      #1;
      vectors++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || A !== 16'h0000) begin
         miscompares++;
         $display("FAIL flush_empty got vld=%b rdy=%b A=%h want 0 1 0000", out_valid, in_ready, A);
      end
      tick();
      #1;
      vectors++;
      if (out_valid !== 1'b0) begin miscompares++; $display("FAIL flush_discard got vld=%b want 0", out_valid); end
   endtask

   task automatic test_snoop();
      out_ready = 0;
      load_op(16'h0000, 16'h0000, 3'd5, 1, 4'd6);
      tick();
      in_valid = 0;
      mwb_wr = 1; mwb_rd = 5; mwb_data = 16'h00AA;
      tick();
      mwb_wr = 0; mwb_data = 16'h0000;
      #1;
      vectors++;
      if (out_valid !== 1'b1 || A !== 16'h00AA || Op !== 4'd6) begin
         miscompares++;
         $display("FAIL snoop_update got vld=%b A=%h Op=%h want 1 00AA 6", out_valid, A, Op);
      end
      out_ready = 1;
      tick();
   endtask

   task automatic test_random();
      logic [45:0] got, want;
      for (int n = 0; n < 400; n++) begin
         rst       = ($urandom_range(0, 63) != 0);
         flush     = ($urandom_range(0, 15) == 0);
         in_valid  = $urandom_range(0, 1);
         out_ready = ($urandom_range(0, 3) != 0);
         in_a = 16'($urandom); in_b = 16'($urandom);
         in_rs_a = 3'($urandom); in_rs_b = 3'($urandom);
         in_use_a = $urandom_range(0, 1); in_use_b = $urandom_range(0, 1);
         in_rd = 3'($urandom); in_wr = $urandom_range(0, 1); in_cin = $urandom_range(0, 1);
         in_op = 4'($urandom); in_inva = $urandom_range(0, 1); in_invb = $urandom_range(0, 1);
         in_sign = $urandom_range(0, 1);
         exm_wr = ($urandom_range(0, 2) == 0); exm_rd = 3'($urandom); exm_data = 16'($urandom);
         mwb_wr = ($urandom_range(0, 2) == 0); mwb_rd = 3'($urandom); mwb_data = 16'($urandom);
         #1;
         model_outputs();
         got  = {out_valid, A, B, Cin, Op, invA, invB, sign, out_rd, out_wr, in_ready};
         want = {exp_valid, exp_a, exp_b, exp_cin, exp_op, exp_inva, exp_invb, exp_sign,
                 exp_rd, exp_wr, exp_in_ready};
         vectors++;
         if (got !== want) begin
            miscompares++;
            $display("FAIL random cycle %0d got=%h want=%h", n, got, want);
         end
         tick();
      end
      rst = 1;
      idle_inputs();
   endtask

   initial begin
      rst = 0; out_ready = 0;
      idle_inputs();
      @(negedge clk);
      test_reset();
      test_single();
      test_back_to_back();
      test_hazard();
      test_flush();
      test_snoop();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
